// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types and default constants (receiver/transmitter).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 8;
    localparam int UART_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync2
// Description : Two-flop synchronizer for a single asynchronous input, with a
//               configurable reset value (idle level of the source).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : uart_sync2
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : uart_receiver
// Description : UART receive path: recovers start/data/stop frames from an
//               asynchronous serial line, strobes Valid per good byte and
//               FrameErr on a low stop bit. Optional even-parity checking is
//               enabled with the UART_RX_PARITY_EN macro (adds ParityErr).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic                 EN,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] DataOUT,
    output logic                 Valid,
    output logic                 FrameErr,
`ifdef UART_RX_PARITY_EN
    output logic                 ParityErr,
`endif
    output logic                 Busy
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam int c_BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [c_CNT_W-1:0] c_HALF_M1  = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_BIT_M1   = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(DATA_BITS - 1);

    rx_state_t            r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_BIT_W-1:0]   r_bitcnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
`ifdef UART_RX_PARITY_EN
    logic                 r_par_bit;
    logic                 r_parity_err;
`endif

    logic w_rxs;
    logic w_tick;

    uart_sync2 #(
        .RST_VAL (1'b1)
    ) u_sync_rx (
        .clk (CLK),
        .rst (Reset),
        .i_d (rx),
        .o_q (w_rxs)
    );

    assign w_tick = (r_cnt == '0);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            // Dropping EN abandons any partial frame without reporting it.
            if ((r_state != IDLE) && !EN) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (EN && !w_rxs) begin
                            r_state  <= START;
                            r_cnt    <= c_HALF_M1;
                            r_bitcnt <= '0;
                        end
                    end
                    START: begin
                        if (w_tick) begin
                            if (!w_rxs) begin
                                r_state <= DATA;
                                r_cnt   <= c_BIT_M1;
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    DATA: begin
                        if (w_tick) begin
                            r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
                            r_cnt   <= c_BIT_M1;
                            if (r_bitcnt == c_LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                                r_state <= PARITY;
`else
                                r_state <= STOP;
`endif
                            end else begin
                                r_bitcnt <= r_bitcnt + 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    PARITY: begin
`ifdef UART_RX_PARITY_EN
                        if (w_tick) begin
                            r_par_bit <= w_rxs;
                            r_cnt     <= c_BIT_M1;
                            r_state   <= STOP;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
`else
                        r_state <= IDLE;
`endif
                    end
                    STOP: begin
                        if (w_tick) begin
                            // Returning to IDLE mid-stop-bit leaves time to catch
                            // a start edge that directly follows.
                            if (w_rxs) begin
                                r_state <= IDLE;
`ifdef UART_RX_PARITY_EN
                                if ((^r_shift) != r_par_bit) begin
                                    r_parity_err <= 1'b1;
                                end else begin
                                    r_data  <= r_shift;
                                    r_valid <= 1'b1;
                                end
`else
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
`endif
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= BREAK;
                            end
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    BREAK: begin
                        if (w_rxs) begin
                            r_state <= IDLE;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign DataOUT  = r_data;
    assign Valid    = r_valid;
    assign FrameErr = r_frame_err;
    assign Busy     = (r_state != IDLE);
`ifdef UART_RX_PARITY_EN
    assign ParityErr = r_parity_err;
`endif

endmodule : uart_receiver
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_receiver
// Description : Randomized self-checking bench for uart_receiver; frames are
//               built bit-by-bit and expected outcomes come from frame rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

    localparam int CPB = 8;
    localparam int DB  = 8;
`ifdef UART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    typedef struct {
        int         kind;   // 0 = Valid, 1 = FrameErr, 2 = ParityErr
        logic [7:0] data;   // DataOUT expected while the pulse is high
        int         cyc;    // cycle in which the pulse is expected
    } ev_t;

    logic       CLK = 1'b0;
    logic       Reset;
    logic       EN;
    logic       rx;
    logic [7:0] DataOUT;
    logic       Valid;
    logic       FrameErr;
    logic       Busy;
`ifdef UART_RX_PARITY_EN
    logic       ParityErr;
`endif

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic [7:0] last_good = 8'h00;
    ev_t        exp_q[$];
    ev_t        mon_e;
    int         mon_kind;
    int         mon_cnt;

    uart_receiver #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB)
    ) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .EN       (EN),
        .rx       (rx),
        .DataOUT  (DataOUT),
        .Valid    (Valid),
        .FrameErr (FrameErr),
`ifdef UART_RX_PARITY_EN
        .ParityErr(ParityErr),
`endif
        .Busy     (Busy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Every output pulse must match the next outcome predicted by the frame rules.
    always @(negedge CLK) begin
        if (!Reset) begin
            mon_kind = Valid ? 0 : (FrameErr ? 1 : 2);
            mon_cnt  = int'(Valid) + int'(FrameErr);
`ifdef UART_RX_PARITY_EN
            mon_cnt  = mon_cnt + int'(ParityErr);
`endif
            if (mon_cnt != 0) begin
                check_eq("one_pulse", mon_cnt, 1);
                if (exp_q.size() == 0) begin
                    check_eq("spurious_pulse", mon_kind + 100, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("pulse_kind", mon_kind, mon_e.kind);
                    check_eq("pulse_data", DataOUT, mon_e.data);
                    check_eq("pulse_cycle", cyc, mon_e.cyc);
                end
            end
        end
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Called and returns at 1 time unit after a rising edge.
    task automatic send_frame(input logic [7:0] d, input bit stop_bit, input bit par_bit);
        ev_t e;
        e.cyc = cyc + 3 + CPB / 2 + CPB * (DB + 1 + PAR);
        if (!stop_bit) begin
            e.kind = 1;
            e.data = last_good;
        end else if ((PAR == 1) && (par_bit != ^d)) begin
            e.kind = 2;
            e.data = last_good;
        end else begin
            e.kind    = 0;
            e.data    = d;
            last_good = d;
        end
        exp_q.push_back(e);
        rx = 1'b0;
        repeat (CPB) @(posedge CLK);
        #1;
        check_eq("busy_in_frame", Busy, 1);
        for (int i = 0; i < DB; i++) begin
            rx = d[i];
            repeat (CPB) @(posedge CLK);
            #1;
        end
`ifdef UART_RX_PARITY_EN
        rx = par_bit;
        repeat (CPB) @(posedge CLK);
        #1;
`endif
        rx = stop_bit;
        repeat (CPB) @(posedge CLK);
        #1;
    endtask

    // Drives start plus data bits 0..3 and stops halfway through data bit 4.
    task automatic send_partial(input logic [7:0] d);
        rx = 1'b0;
        repeat (CPB) @(posedge CLK);
        #1;
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            repeat (CPB) @(posedge CLK);
            #1;
        end
        rx = d[4];
        repeat (CPB / 2) @(posedge CLK);
        #1;
    endtask

    task automatic expect_drained(input string tag);
        check_eq(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        bit         stop_b;
        bit         prev_bad;
        Reset = 1'b1;
        EN    = 1'b1;
        rx    = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check_eq("rst_dataout", DataOUT, 8'h00);
        check_eq("rst_valid", Valid, 0);
        check_eq("rst_frameerr", FrameErr, 0);
        check_eq("rst_busy", Busy, 0);
        Reset = 1'b0;
        idle(2 * CPB);

        // Single good frame
        send_frame(8'hA5, 1'b1, ^8'hA5);
        idle(CPB);
        check_eq("a5_busy_after", Busy, 0);
        check_eq("a5_dataout", DataOUT, 8'hA5);
        expect_drained("a5_missing");

        // Back-to-back frames with no idle gap
        send_frame(8'hF0, 1'b1, ^8'hF0);
        send_frame(8'h0F, 1'b1, ^8'h0F);
        idle(CPB);
        expect_drained("b2b_missing");

        // Framing error followed by a held-low line
        send_frame(8'h3C, 1'b0, ^8'h3C);
        rx = 1'b0;
        repeat (20 * CPB) @(posedge CLK);
        #1;
        check_eq("break_busy", Busy, 1);
        check_eq("ferr_hold_data", DataOUT, last_good);
        idle(2 * CPB);
        check_eq("break_exit_busy", Busy, 0);
        expect_drained("ferr_missing");

        // Short low glitch on the line
        rx = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        rx = 1'b1;
        check_eq("glitch_busy", Busy, 1);
        idle(2 * CPB);
        check_eq("glitch_busy_after", Busy, 0);

        // Reset in the middle of data bit 4
        d = 8'($urandom);
        send_partial(d);
        Reset = 1'b1;
        rx    = 1'b1;
        @(posedge CLK);
        #1;
        Reset     = 1'b0;
        last_good = 8'h00;
        check_eq("midrst_dataout", DataOUT, 8'h00);
        check_eq("midrst_busy", Busy, 0);
        idle((DB + 3) * CPB);
        send_frame(8'h81, 1'b1, ^8'h81);
        idle(CPB);
        expect_drained("midrst_missing");

        // EN dropped in the middle of data bit 4
        d = 8'($urandom);
        send_partial(d);
        EN = 1'b0;
        rx = 1'b1;
        @(posedge CLK);
        #1;
        EN = 1'b1;
        idle((DB + 3) * CPB);
        check_eq("en_abort_busy", Busy, 0);
        send_frame(8'h81, 1'b1, ^8'h81);
        idle(CPB);
        expect_drained("en_abort_missing");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        idle(CPB);
        send_frame(8'h07, 1'b1, 1'b1);
        idle(CPB);
        check_eq("par_dataout", DataOUT, 8'h07);
        expect_drained("par_missing");
`endif

        // Randomized frames, gaps and stop bits
        prev_bad = 1'b0;
        for (int n = 0; n < 16; n++) begin
            d      = 8'($urandom);
            stop_b = ($urandom_range(0, 4) != 0);
            if (prev_bad) idle(CPB * int'($urandom_range(1, 2)));
            else          idle(CPB * int'($urandom_range(0, 2)));
            send_frame(d, stop_b, ($urandom_range(0, 5) == 0) ? ~(^d) : (^d));
            prev_bad = !stop_b;
        end
        idle(2 * CPB);
        check_eq("rand_hold_data", DataOUT, last_good);
        check_eq("rand_busy_after", Busy, 0);
        expect_drained("rand_missing");

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule : tb_uart_receiver
`default_nettype wire
